// File: rtl/seg16_scroll_sink.sv
`default_nettype none
// ============================================================================
// Module   : seg16_scroll_sink
// Purpose  : Character-stream sink for a four-digit 16-segment display.
//            ASCII bytes arrive over a valid/ready handshake, are queued in a
//            small FIFO, and on every scroll tick the oldest byte is encoded
//            and shifted into the rightmost digit (digits move left).
// Ports    : clk       - system clock
//            rst_n     - synchronous active-low reset
//            in_valid  - upstream byte valid
//            in_data   - ASCII byte
//            in_ready  - FIFO can accept a byte this cycle (registered)
//            LEDa..d   - digit segments, active-low, LEDa leftmost
//            empty     - FIFO empty
//            bad_char  - one-cycle pulse: unsupported byte shown as blank
// Revision : 1.0 - initial release
// ============================================================================
module seg16_scroll_sink #(
    parameter int TICK_DIV   = 8388608,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] LEDa,
    output logic [15:0] LEDb,
    output logic [15:0] LEDc,
    output logic [15:0] LEDd,
    output logic        empty,
    output logic        bad_char
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] C_TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [AW:0]   C_FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0]   C_BLANK     = 16'hFFFF;

    // ------------------------------------------------------------------
    // Scroll tick divider
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt;
    logic          w_tick;

    assign w_tick = (r_cnt == C_TICK_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [AW:0]   w_level_next;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;

    assign w_push = in_valid && r_ready;
    // Pop eligibility uses the registered level, so a byte written this
    // cycle into an empty FIFO cannot be popped until the next cycle.
    assign w_pop  = w_tick && (r_level != '0);
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + (AW + 1)'(1);
            2'b01:   w_level_next = r_level - (AW + 1)'(1);
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_next;
            r_ready <= (w_level_next != C_FULL_LVL);
        end
    end

    assign in_ready = r_ready;
    assign empty    = (r_level == '0);

    // ------------------------------------------------------------------
    // ASCII -> 16-segment encoder (upper case folded to lower)
    // ------------------------------------------------------------------
    logic [7:0]  w_lc;
    logic [15:0] w_seg;
    logic        w_bad;

    always_comb begin
        w_lc = w_head;
        if (w_head >= 8'h41 && w_head <= 8'h5A) begin
            w_lc = w_head | 8'h20;
        end
        w_seg = C_BLANK;
        w_bad = 1'b0;
        case (w_lc)
            8'h20:   w_seg = C_BLANK;
            8'h61:   w_seg = 16'b1111000101111101; // a
            8'h65:   w_seg = 16'b1111010101111110; // e
            8'h68:   w_seg = 16'b1111110001111101; // h
            8'h73:   w_seg = 16'b0111011001111101; // s
            8'h77:   w_seg = 16'b1110110111111010; // w
            default: begin
                w_seg = C_BLANK;
                w_bad = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Display shift register
    // ------------------------------------------------------------------
    logic [15:0] r_led_a;
    logic [15:0] r_led_b;
    logic [15:0] r_led_c;
    logic [15:0] r_led_d;
    logic        r_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led_a <= C_BLANK;
            r_led_b <= C_BLANK;
            r_led_c <= C_BLANK;
            r_led_d <= C_BLANK;
            r_bad   <= 1'b0;
        end else begin
            r_bad <= w_pop && w_bad;
            if (w_pop) begin
                r_led_a <= r_led_b;
                r_led_b <= r_led_c;
                r_led_c <= r_led_d;
                r_led_d <= w_seg;
            end
        end
    end

    assign LEDa     = r_led_a;
    assign LEDb     = r_led_b;
    assign LEDc     = r_led_c;
    assign LEDd     = r_led_d;
    assign bad_char = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_seg16_scroll_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg16_scroll_sink
// Purpose  : Self-checking bench for seg16_scroll_sink (TICK_DIV=4,
//            FIFO_DEPTH=8). A queue-based reference model tracks the
//            expected display and FIFO state; outputs are compared every
//            cycle, and directed scenarios add hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg16_scroll_sink;

    localparam int TD = 4;
    localparam int FD = 8;

    localparam logic [15:0] S_A  = 16'b1111000101111101;
    localparam logic [15:0] S_E  = 16'b1111010101111110;
    localparam logic [15:0] S_H  = 16'b1111110001111101;
    localparam logic [15:0] S_S  = 16'b0111011001111101;
    localparam logic [15:0] S_W  = 16'b1110110111111010;
    localparam logic [15:0] S_BL = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [15:0] LEDa, LEDb, LEDc, LEDd;
    logic        empty;
    logic        bad_char;

    seg16_scroll_sink #(.TICK_DIV(TD), .FIFO_DEPTH(FD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .LEDa     (LEDa),
        .LEDb     (LEDb),
        .LEDc     (LEDc),
        .LEDd     (LEDd),
        .empty    (empty),
        .bad_char (bad_char)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] fold(input logic [7:0] b);
        return (b >= "A" && b <= "Z") ? b + 8'd32 : b;
    endfunction

    function automatic logic [15:0] enc(input logic [7:0] b);
        case (fold(b))
            "a":     return S_A;
            "e":     return S_E;
            "h":     return S_H;
            "s":     return S_S;
            "w":     return S_W;
            default: return S_BL;
        endcase
    endfunction

    function automatic bit supported(input logic [7:0] b);
        return fold(b) inside {" ", "a", "e", "h", "s", "w"};
    endfunction

    logic [7:0]  m_q[$];
    logic [15:0] m_disp [4];
    bit          m_ready = 0;
    bit          m_bad = 0;
    bit          m_init = 0;
    int          m_cyc = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < 4; i++) m_disp[i] = S_BL;
            m_cyc   = 0;
            m_ready = 0;
            m_bad   = 0;
            m_init  = 1;
        end else begin
            bit tick, acc;
            logic [7:0] b;
            tick  = (m_cyc % TD) == TD - 1;
            m_cyc = m_cyc + 1;
            acc   = in_valid && m_ready;
            m_bad = 0;
            if (tick && m_q.size() > 0) begin
                b = m_q.pop_front();
                for (int i = 0; i < 3; i++) m_disp[i] = m_disp[i+1];
                m_disp[3] = enc(b);
                m_bad = !supported(b);
            end
            if (acc) m_q.push_back(in_data);
            m_ready = m_q.size() < FD;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("LEDa", LEDa, m_disp[0]);
            chk("LEDb", LEDb, m_disp[1]);
            chk("LEDc", LEDc, m_disp[2]);
            chk("LEDd", LEDd, m_disp[3]);
            chk("in_ready", {15'd0, in_ready}, {15'd0, m_ready});
            chk("empty", {15'd0, empty}, {15'd0, m_q.size() == 0});
            chk("bad_char", {15'd0, bad_char}, {15'd0, m_bad});
        end
    end

    // ---------------- stimulus helpers ----------------
    bit saw_full = 0;

    task automatic push(input logic [7:0] b);
        bit acc;
        int tries;
        in_valid = 1'b1;
        in_data  = b;
        acc      = 0;
        tries    = 0;
        while (!acc && tries < 100) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) saw_full = 1;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL push_timeout: byte %h not accepted, expected acceptance within 100 cycles", b);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int cnt;
        string msg;

        // ---- Reset check ----
        in_valid = 1'b1;
        in_data  = "a";
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_LEDa", LEDa, S_BL);
        chk("rst_LEDd", LEDd, S_BL);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_empty", {15'd0, empty}, 16'd1);
        rst_n = 1'b1;
        @(posedge clk); // e1: in_ready still low, nothing accepted
        @(negedge clk);
        chk("rel_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rel_empty", {15'd0, empty}, 16'd1);
        @(posedge clk); // e2: 'a' accepted
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_not_empty", {15'd0, empty}, 16'd0);
        @(posedge clk); // e3
        @(negedge clk);
        chk("pre_tick_LEDd", LEDd, S_BL);
        @(posedge clk); // e4: first tick
        @(negedge clk);
        chk("first_tick_LEDd", LEDd, S_A);
        chk("first_tick_empty", {15'd0, empty}, 16'd1);

        // ---- Message "was" ----
        do_reset(2);
        push("w"); push("a"); push("s");
        wait_cyc(20);
        @(negedge clk);
        chk("was_LEDa", LEDa, S_BL);
        chk("was_LEDb", LEDb, S_W);
        chk("was_LEDc", LEDc, S_A);
        chk("was_LEDd", LEDd, S_S);

        // ---- Full FIFO ----
        do_reset(2);
        saw_full = 0;
        msg = "wash hawse shh";
        for (int i = 0; i < msg.len(); i++) push(msg[i]);
        chk("full_seen", {15'd0, saw_full}, 16'd1);
        wait_cyc(80);
        @(negedge clk);
        chk("full_drain_empty", {15'd0, empty}, 16'd1);
        chk("full_LEDb", LEDb, S_S);
        chk("full_LEDc", LEDc, S_H);
        chk("full_LEDd", LEDd, S_H);

        // ---- Empty hold with case folding ----
        do_reset(2);
        push("H"); push("E");
        wait_cyc(12);
        @(negedge clk);
        chk("he_LEDc", LEDc, S_H);
        chk("he_LEDd", LEDd, S_E);
        wait_cyc(40);
        @(negedge clk);
        chk("hold_LEDb", LEDb, S_BL);
        chk("hold_LEDc", LEDc, S_H);
        chk("hold_LEDd", LEDd, S_E);

        // ---- Bad char ----
        do_reset(2);
        push("#");
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bad_char) cnt++;
        end
        chk("bad_pulse_count", 16'(cnt), 16'd1);
        chk("bad_LEDd", LEDd, S_BL);
        @(posedge clk);
        #1;
        push("h");
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bad_char) cnt++;
        end
        chk("good_pulse_count", 16'(cnt), 16'd0);
        chk("good_LEDd", LEDd, S_H);
        chk("good_LEDc", LEDc, S_BL);

        // ---- Reset mid-stream ----
        do_reset(2);
        msg = "hawse";
        for (int i = 0; i < msg.len(); i++) push(msg[i]);
        wait_cyc(3);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_LEDc", LEDc, S_BL);
        chk("mid_LEDd", LEDd, S_BL);
        chk("mid_empty", {15'd0, empty}, 16'd1);
        rst_n = 1'b1;
        wait_cyc(20);
        @(negedge clk);
        chk("post_LEDd", LEDd, S_BL);
        chk("post_empty", {15'd0, empty}, 16'd1);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg16_scroll_sink.md
# seg16_scroll_sink

Character-stream consumer for the four-digit 16-segment display. Accepts ASCII bytes from an upstream message source over a valid/ready handshake and buffers them in a small FIFO. Each byte is encoded to an active-low 16-segment pattern and shifted into the rightmost digit on every scroll tick. It replaces hard-coded scroll sequencing: any producer can now write text to the display.

## Interface
Parameters:
- TICK_DIV, 8388608 (2^23): clk cycles per scroll tick; legal range ≥ 2.
- FIFO_DEPTH, 8: character buffer entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock (on-chip oscillator, nominal 12.09 MHz).
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  ASCII byte.
- in_ready  out  1  FIFO can accept a byte this cycle.
- LEDa  out  16  leftmost digit segments, active-low (1 = off).
- LEDb  out  16  digit 2, active-low.
- LEDc  out  16  digit 3, active-low.
- LEDd  out  16  rightmost digit, active-low.
- empty  out  1  FIFO empty.
- bad_char  out  1  one-cycle pulse: an unsupported byte was displayed as blank.

## Operation
- Handshake: a byte is accepted on any rising clk where in_valid && in_ready. in_data is sampled only then. in_valid may assert independently of in_ready.
- in_ready = !full, registered state only; no same-cycle pass-through when full.
- Tick counter: counts 0..TICK_DIV-1, then wraps to 0. A tick is the cycle where the count equals TICK_DIV-1.
- On a tick with FIFO non-empty: pop the head, then LEDa←LEDb, LEDb←LEDc, LEDc←LEDd, LEDd←enc(head), all in the same cycle.
- On a tick with FIFO empty: no shift; all digits hold.
- Encoder, with upper case folded to lower before lookup:
  - 0x20 space → 1111111111111111.
  - 'a' → 1111000101111101.
  - 'e' → 1111010101111110.
  - 'h' → 1111110001111101.
  - 's' → 0111011001111101.
  - 'w' → 1110110111111010.
  - Any other byte → 1111111111111111, and bad_char pulses in the shift cycle.
- Simultaneous push and pop in one cycle: both happen, and the level is unchanged.
- Push into an empty FIFO: the byte cannot be popped by a tick in the same cycle. It becomes eligible from the next cycle.

## Timing
- Reset (rst_n low at a clk edge) sets:
  - LEDa..LEDd = 16'hFFFF.
  - Tick count = 0, FIFO cleared, empty = 1, bad_char = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 on the first cycle after release.
- Reset mid-operation discards buffered bytes and blanks the display at that edge. A byte offered in that cycle is not accepted.
- First tick is the TICK_DIV-th cycle after reset release. Ticks then repeat every TICK_DIV cycles, independent of FIFO activity.
- LED outputs and bad_char are registered; they change only on the clk edge ending a tick cycle.
- Latency: a byte accepted at edge N appears in LEDd at the first tick edge strictly after N. It reaches LEDa three non-empty ticks later.
- empty and in_ready reflect the FIFO level after each edge: full after FIFO_DEPTH net pushes, empty after all pops.

## Test plan
All scenarios use TICK_DIV=4 and FIFO_DEPTH=8.
- Reset check: hold rst_n low 3 cycles with in_valid=1 → LEDa..LEDd=FFFF, in_ready=0, empty=1. Release → in_ready=1 next cycle, first shift at the 4th cycle.
- Message "was": push 'w','a','s' back-to-back, then wait 3 ticks → LEDb=1110110111111010, LEDc=1111000101111101, LEDd=0111011001111101, LEDa=FFFF.
- Full FIFO: push 8 bytes with no tick → in_ready=0. A 9th byte held valid is not accepted until the next tick pops. Byte order is preserved on the display.
- Empty hold: display "HE" (uppercase), then idle 10 ticks → digits unchanged. LEDd=1111010101111110, proving case folding.
- Bad char: push '#' → FFFF shifted into LEDd and bad_char high for exactly 1 cycle. Push 'h' next → shifts normally, bad_char stays 0.
- Reset mid-stream: push 5 bytes, assert rst_n low after 2 ticks → all LEDs FFFF, empty=1. No remaining bytes appear after release.
